board_io_debounce: RTL and testbench

Parametrised board-input conditioning block for the FPGA top levels. It synchronises NumIn raw switch/button pins, applies optional per-bit polarity inversion, and debounces each channel against a shared sample tick. It emits clean levels plus one-cycle rise/fall pulses, and provides a free-running heartbeat bit for an LED or PMOD debug pin. It sits between the board pins and the demo system's GPIO inputs, and generalises the ad-hoc LED-shift debug counter and raw `{SW, BTN}` wiring.

---
 rtl/board_io_debounce.sv | 100 ++++++++++
 tb/tb_board_io_debounce.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_debounce.sv
// Board input conditioning: per-bit polarity fix, 2-flop sync, tick-based debounce with
// rise/fall pulses, plus a free-running heartbeat bit.
module board_io_debounce #(
    parameter int unsigned           NumIn         = 8,
    parameter int unsigned           TickDiv       = 500,
    parameter int unsigned           StableTicks   = 100,
    parameter logic [NumIn-1:0]      ActiveLowMask = '0,
    parameter int unsigned           HeartbeatBit  = 23
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [NumIn-1:0] in_i,
    output logic [NumIn-1:0] level_o,
    output logic [NumIn-1:0] rise_o,
    output logic [NumIn-1:0] fall_o,
    output logic             changed_o,
    output logic             tick_o,
    output logic             heartbeat_o
);

    localparam int unsigned TickW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int unsigned CntW  = $clog2(StableTicks + 1);
    localparam int unsigned HbW   = HeartbeatBit + 1;

    localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(StableTicks - 1);

    logic [NumIn-1:0] sync1_q, sync1_d;
    logic [NumIn-1:0] sync2_q, sync2_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [CntW-1:0]  cnt_q [NumIn];
    logic [CntW-1:0]  cnt_d [NumIn];
    logic [NumIn-1:0] level_q, level_d;
    logic [NumIn-1:0] rise_q, rise_d;
    logic [NumIn-1:0] fall_q, fall_d;
    logic [HbW-1:0]   hb_q, hb_d;
    logic             tick;

    assign tick = (tick_cnt_q == TickLast);

    always_comb begin
        sync1_d    = in_i ^ ActiveLowMask;
        sync2_d    = sync1_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        hb_d       = hb_q + 1'b1;
        level_d    = level_q;
        rise_d     = '0;
        fall_d     = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntLast) begin
                    // Qualified: adopt the new level and flag the edge in the same update.
                    cnt_d[i]   = '0;
                    level_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            level_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            hb_q       <= '0;
            for (int i = 0; i < int'(NumIn); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_cnt_q <= tick_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            hb_q       <= hb_d;
            for (int i = 0; i < int'(NumIn); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign changed_o   = |(rise_q | fall_q);
    assign tick_o      = tick;
    assign heartbeat_o = hb_q[HeartbeatBit];

endmodule

// File: tb/tb_board_io_debounce.sv
// Bench for board_io_debounce: directed timing scenarios plus randomized pin activity
// compared cycle-by-cycle against a cycle-indexed reference model.
module tb_board_io_debounce;

    localparam int unsigned NumIn   = 4;
    localparam int unsigned TickDiv = 4;
    localparam int unsigned Stable  = 3;
    localparam logic [3:0]  Mask    = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pin = 4'b1000;
    logic [3:0] level_o, rise_o, fall_o;
    logic       changed_o, tick_o, heartbeat_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: masked input history indexed by cycle since reset release.
    logic [3:0] hist [$];
    int         m_cnt [4];
    logic [3:0] m_lvl, m_rise, m_fall;

    board_io_debounce #(
        .NumIn        (NumIn),
        .TickDiv      (TickDiv),
        .StableTicks  (Stable),
        .ActiveLowMask(Mask),
        .HeartbeatBit (3)
    ) dut (
        .clk_sys_i  (clk),
        .rst_sys_i  (rst),
        .in_i       (pin),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .changed_o  (changed_o),
        .tick_o     (tick_o),
        .heartbeat_o(heartbeat_o)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        hist.delete();
        m_lvl  = '0;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // Hold reset for n edges, then release with pins p; afterwards the bench sits in cycle 0.
    task automatic do_reset(input int n, input logic [3:0] p);
        rst = 1'b1;
        pin = p;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        model_clear();
    endtask

    // Apply p for the current cycle, advance the model over this cycle, move to the next cycle.
    task automatic step(input logic [3:0] p);
        logic [3:0] s2;
        pin = p;
        hist.push_back(p ^ Mask);
        s2     = (cyc >= 2) ? hist[cyc-2] : 4'b0000;
        m_rise = '0;
        m_fall = '0;
        if (cyc % TickDiv == TickDiv - 1) begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == m_lvl[i]) m_cnt[i] = 0;
                else if (m_cnt[i] + 1 < Stable) m_cnt[i]++;
                else begin
                    m_cnt[i]  = 0;
                    m_lvl[i]  = s2[i];
                    m_rise[i] = s2[i];
                    m_fall[i] = !s2[i];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        do_reset(3, 4'b1000);
        for (int k = 0; k < 18; k++) begin
            checks++;
            if ({level_o, rise_o, fall_o, changed_o} !== 13'd0) begin
                errors++;
                $display("FAIL reset_idle_outputs cyc=%0d got=%h want=0", cyc,
                         {level_o, rise_o, fall_o, changed_o});
            end
            checks++;
            if (tick_o !== (cyc == 3 || cyc == 7 || cyc == 11 || cyc == 15)) begin
                errors++;
                $display("FAIL reset_tick cyc=%0d got=%b", cyc, tick_o);
            end
            checks++;
            if (heartbeat_o !== (cyc >= 8 && cyc < 16)) begin
                errors++;
                $display("FAIL heartbeat cyc=%0d got=%b want=%b", cyc, heartbeat_o,
                         (cyc >= 8 && cyc < 16));
            end
            step(4'b1000);
        end
    endtask

    task automatic test_rise_fall();
        int nfall = 0;
        do_reset(2, 4'b1001);
        for (int k = 0; k < 34; k++) begin
            logic [3:0] p;
            logic       want_lvl;
            p        = (cyc < 16) ? 4'b1001 : 4'b1000;
            want_lvl = (cyc >= 12 && cyc < 28);
            checks++;
            if (level_o[0] !== want_lvl || rise_o[0] !== (cyc == 12) ||
                changed_o !== (cyc == 12 || cyc == 28) || fall_o[0] !== (cyc == 28)) begin
                errors++;
                $display("FAIL rise_fall cyc=%0d lvl=%b rise=%b fall=%b chg=%b want_lvl=%b",
                         cyc, level_o[0], rise_o[0], fall_o[0], changed_o, want_lvl);
            end
            if (fall_o[0] === 1'b1) nfall++;
            step(p);
        end
        checks++;
        if (nfall != 1) begin
            errors++;
            $display("FAIL fall_pulse_count got=%0d want=1", nfall);
        end
    endtask

    task automatic test_glitch();
        do_reset(2, 4'b1010);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (level_o[1] !== 1'b0 || rise_o[1] !== 1'b0 || fall_o[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_rejected cyc=%0d lvl=%b rise=%b fall=%b", cyc,
                         level_o[1], rise_o[1], fall_o[1]);
            end
            step((cyc <= 4) ? 4'b1010 : 4'b1000);
        end
    endtask

    task automatic test_active_low();
        do_reset(2, 4'b0000);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (level_o !== ((cyc >= 12) ? 4'b1000 : 4'b0000) ||
                rise_o !== ((cyc == 12) ? 4'b1000 : 4'b0000) || fall_o !== 4'b0000) begin
                errors++;
                $display("FAIL active_low cyc=%0d lvl=%b rise=%b fall=%b", cyc, level_o,
                         rise_o, fall_o);
            end
            step(4'b0000);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2, 4'b1100);
        while (cyc < 9) step(4'b1100);
        do_reset(1, 4'b1100);
        checks++;
        if ({level_o, rise_o, fall_o, changed_o, tick_o, heartbeat_o} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_clear got=%h want=0",
                     {level_o, rise_o, fall_o, changed_o, tick_o, heartbeat_o});
        end
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (level_o[2] !== (cyc >= 12) || rise_o[2] !== (cyc == 12)) begin
                errors++;
                $display("FAIL reset_mid_requalify cyc=%0d lvl=%b rise=%b", cyc, level_o[2],
                         rise_o[2]);
            end
            step(4'b1100);
        end
    endtask

    task automatic test_random();
        logic [3:0] p;
        int         hold;
        do_reset(2, 4'b1000);
        p    = 4'b1000;
        hold = 0;
        for (int k = 0; k < 800; k++) begin
            checks++;
            if (level_o !== m_lvl || rise_o !== m_rise || fall_o !== m_fall ||
                changed_o !== |(m_rise | m_fall) || tick_o !== (cyc % TickDiv == TickDiv - 1) ||
                heartbeat_o !== ((cyc / 8) % 2 == 1)) begin
                errors++;
                $display("FAIL random cyc=%0d lvl=%b/%b rise=%b/%b fall=%b/%b tick=%b hb=%b",
                         cyc, level_o, m_lvl, rise_o, m_rise, fall_o, m_fall, tick_o,
                         heartbeat_o);
            end
            if (hold == 0) begin
                // Flip a random subset; long holds let channels qualify, short ones glitch.
                p    = p ^ 4'($urandom_range(1, 15));
                hold = $urandom_range(1, 20);
            end
            hold--;
            step(p);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_rise_fall();
        test_glitch();
        test_active_low();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
